lcd_char_disp: RTL and testbench
================================

LCD_CHAR_DISP -- requirements
Module: lcd_char_disp

Interface
REQ-001 SHALL have parameter TEXT_Y, default 11'd120; top row of the text box (0-based display row).
REQ-002 SHALL have parameter SCROLL_DIV, default 8'd2; frames per horizontal scroll step (legal range 1..255).
REQ-003 SHALL have parameter X_STEP, default 11'd1; pixels moved per scroll step.
REQ-004 SHALL have parameter FG_COLOR, default 16'hF800; RGB565 glyph colour.
REQ-005 SHALL have parameter BG_COLOR, default 16'hFFFF; RGB565 background colour.
REQ-006 SHALL have port lcd_pclk, input, 1 bit; the only clock, LCD pixel clock.
REQ-007 SHALL have port rst, input, 1 bit; reset, synchronous and active-high.
REQ-008 SHALL have port pixel_xpos, input, 11 bits; requested column, 1-based, 0 when no request.
REQ-009 SHALL have port pixel_ypos, input, 11 bits; requested row, 1-based, 0 when no request.
REQ-010 SHALL have port h_disp, input, 11 bits; active horizontal resolution.
REQ-011 SHALL have port v_disp, input, 11 bits; active vertical resolution.
REQ-012 SHALL have port pixel_data, output, 16 bits; registered RGB565 pixel for the LCD timing stage.
REQ-013 SHALL have port frame_done, output, 1 bit; one-cycle pulse after the last active pixel of a frame.

Function
REQ-014 A request SHALL be valid when pixel_xpos != 0; x = pixel_xpos-1 and y = pixel_ypos-1.
REQ-015 pixel_data SHALL be updated exactly 1 lcd_pclk after its request, matching the timing stage's one-clock-early data request.
REQ-016 An invalid request SHALL yield pixel_data = 16'h0000 on the next cycle.
REQ-017 The text box SHALL be 8 characters x 16 px wide (128 px) and 32 px high, spanning box_x <= x < box_x+128 and TEXT_Y <= y < TEXT_Y+32.
REQ-018 Inside the box: col = x-box_x, char index = col[6:4], glyph bit = 15-col[3:0] (MSB leftmost), glyph row = y-TEXT_Y.
REQ-019 The pixel SHALL be FG_COLOR when the glyph bit is 1 and BG_COLOR otherwise; valid pixels outside the box SHALL be BG_COLOR.
REQ-020 Text box contents SHALL be the fixed 8-character string from the font ROM (index 0 leftmost).
REQ-021 End of frame SHALL be detected when pixel_xpos == h_disp and pixel_ypos == v_disp; frame_done SHALL pulse high on the following cycle, for exactly 1 cycle.
REQ-022 A frame divider counter (8 bits) SHALL increment at each end of frame and wrap to 0 after SCROLL_DIV-1.
REQ-023 On an end of frame where the divider equals SCROLL_DIV-1: box_x <= 0 if box_x+128+X_STEP > h_disp, otherwise box_x <= box_x+X_STEP.
REQ-024 box_x SHALL change only at end of frame; there SHALL be no tearing within a frame.
REQ-025 If h_disp < 128, box_x SHALL stay 0 and the text SHALL be clipped naturally by the request range.
REQ-026 A change of h_disp/v_disp mid-frame SHALL be applied only at the next detected end of frame; width arithmetic SHALL be done in 12 bits so no overflow occurs.

Reset
REQ-027 While rst is high at a lcd_pclk edge: pixel_data = 16'h0000, frame_done = 0, box_x = 0, divider = 0, blink state = visible.
REQ-028 A reset asserted mid-frame SHALL take effect on the next edge; normal output SHALL resume on the first request after release.

Configuration
REQ-029 Macro LCD_CHAR_BLINK_EN defined: a 5-bit frame counter SHALL toggle visibility every 32 frames; while hidden, in-box pixels SHALL be BG_COLOR.
REQ-030 Macro LCD_CHAR_BLINK_EN undefined: the text SHALL always be visible and no blink logic SHALL be present.

Structure
REQ-031 Package lcd_char_pkg SHALL hold CHAR_W=16, CHAR_H=32, CHAR_NUM=8, BOX_W=128, and the RGB565 colour constants.
REQ-032 Sub-module lcd_font_rom SHALL be combinational: input {char index[2:0], row[4:0]}, output 16-bit glyph row.

Verification
REQ-033 Reset held for 3 cycles with xpos=5, ypos=5 -> pixel_data=0000 and frame_done=0 throughout.
REQ-034 h_disp=480, v_disp=272, pixel request (x=1, y=TEXT_Y+1) after reset -> one cycle later pixel_data equals FG/BG per ROM char 0 row 0 bit 15.
REQ-035 Request (x=200, y=10) -> BG_COLOR (FFFF); request with xpos=0 -> 0000 one cycle later.
REQ-036 Two full 480x272 frames with SCROLL_DIV=2 -> frame_done pulses twice; box_x goes 0 -> 1 after the second frame.
REQ-037 box_x preset to 352 with h_disp=480, scroll step due -> box_x wraps to 0 (352+128+1 > 480).
REQ-038 With LCD_CHAR_BLINK_EN defined, 32 frames run -> in-box glyph pixels read FFFF during frames 32..63 and return at frame 64.

Source files
------------

// File: rtl/lcd_char_pkg.sv
// Shared constants and types for the scrolling LCD character display.
// Text box geometry, RGB565 colours, glyph codes and the fixed text
// string live here so the top and the font ROM agree on them.
package lcd_char_pkg;

  localparam int unsigned CHAR_W   = 16;   // rendered glyph width in pixels
  localparam int unsigned CHAR_H   = 32;   // rendered glyph height in pixels
  localparam int unsigned CHAR_NUM = 8;    // characters in the text box
  localparam int unsigned BOX_W    = CHAR_W * CHAR_NUM;

  localparam int unsigned COORD_W  = 11;   // LCD coordinate width
  localparam int unsigned WIDE_W   = 12;   // width for overflow-free sums
  localparam int unsigned PIX_W    = 16;   // RGB565
  localparam int unsigned DIV_W    = 8;    // frame divider width
  localparam int unsigned BLINK_W  = 5;    // blink frame counter width

  // Source bitmap is 8x16, scaled 2x in both directions to 16x32.
  localparam int unsigned SRC_W    = 8;
  localparam int unsigned SRC_H    = 16;

  localparam logic [PIX_W-1:0] RGB_BLACK = 16'h0000;
  localparam logic [PIX_W-1:0] RGB_WHITE = 16'hFFFF;
  localparam logic [PIX_W-1:0] RGB_RED   = 16'hF800;

  typedef enum logic [2:0] {
    GL_SPACE,
    GL_H,
    GL_E,
    GL_L,
    GL_O,
    GL_BANG
  } glyph_e;

  // Font ROM address: character slot in the box and rendered row.
  typedef struct packed {
    logic [2:0] chr;
    logic [4:0] row;
  } font_addr_t;

  // Fixed text "HELLO !!", slot 0 leftmost.
  function automatic glyph_e text_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return GL_H;
      3'd1:    return GL_E;
      3'd2:    return GL_L;
      3'd3:    return GL_L;
      3'd4:    return GL_O;
      3'd5:    return GL_SPACE;
      default: return GL_BANG;
    endcase
  endfunction

endpackage

// File: rtl/lcd_font_rom.sv
// Combinational font ROM for the fixed 8-character text string.
// Ports:
//   addr_i    - {character slot[2:0], rendered row[4:0]}
//   glyph_c_o - 16-bit rendered glyph row, MSB is the leftmost pixel
module lcd_font_rom
  import lcd_char_pkg::*;
(
  input  font_addr_t       addr_i,
  output logic [PIX_W-1:0] glyph_c_o
);

  // 8-pixel-wide source bitmap row; rows 0..2 and 13..15 are blank margin.
  function automatic logic [SRC_W-1:0] src_row(input glyph_e g, input logic [3:0] r);
    logic [SRC_W-1:0] bits;
    bits = '0;
    case (g)
      GL_H: begin
        if (r >= 4'd3 && r <= 4'd12) bits = (r == 4'd8) ? 8'h7E : 8'h66;
      end
      GL_E: begin
        if (r == 4'd3 || r == 4'd12)     bits = 8'h7E;
        else if (r == 4'd8)              bits = 8'h7C;
        else if (r > 4'd3 && r < 4'd12)  bits = 8'h60;
      end
      GL_L: begin
        if (r >= 4'd3 && r <= 4'd11)     bits = 8'h60;
        else if (r == 4'd12)             bits = 8'h7E;
      end
      GL_O: begin
        if (r == 4'd3 || r == 4'd12)     bits = 8'h3C;
        else if (r > 4'd3 && r < 4'd12)  bits = 8'h66;
      end
      GL_BANG: begin
        if ((r >= 4'd3 && r <= 4'd9) || r == 4'd11 || r == 4'd12) bits = 8'h18;
      end
      default: bits = '0;
    endcase
    return bits;
  endfunction

  logic [SRC_W-1:0] src_bits_c;

  // Each source row covers two rendered rows.
  assign src_bits_c = src_row(text_char(addr_i.chr), addr_i.row[4:1]);

  // Each source bit covers two rendered columns.
  for (genvar k = 0; k < SRC_W; k++) begin : g_hscale
    assign glyph_c_o[2*k+1 -: 2] = {2{src_bits_c[k]}};
  end

endmodule

// File: rtl/lcd_char_disp.sv
// Scrolling 8-character text box renderer for an RGB565 LCD timing stage.
// Answers the timing stage's one-clock-early pixel requests with a
// registered pixel, and slides the text box right every SCROLL_DIV frames,
// wrapping back to column 0 when it would run past the active width.
// Optional build macro LCD_CHAR_BLINK_EN: text toggles visibility every
// 32 frames.
// Ports:
//   lcd_pclk   - pixel clock
//   rst        - synchronous active-high reset
//   pixel_xpos - requested column, 1-based, 0 = no request
//   pixel_ypos - requested row, 1-based
//   h_disp     - active horizontal resolution
//   v_disp     - active vertical resolution
//   pixel_data - registered RGB565 pixel, one clock after the request
//   frame_done - one-cycle pulse after the last active pixel of a frame
module lcd_char_disp
  import lcd_char_pkg::*;
#(
  parameter logic [10:0] TEXT_Y     = 11'd120,
  parameter logic [7:0]  SCROLL_DIV = 8'd2,
  parameter logic [10:0] X_STEP     = 11'd1,
  parameter logic [15:0] FG_COLOR   = 16'hF800,
  parameter logic [15:0] BG_COLOR   = 16'hFFFF
) (
  input  logic               lcd_pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pixel_xpos,
  input  logic [COORD_W-1:0] pixel_ypos,
  input  logic [COORD_W-1:0] h_disp,
  input  logic [COORD_W-1:0] v_disp,
  output logic [PIX_W-1:0]   pixel_data,
  output logic               frame_done
);

  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic               frame_done_q, frame_done_d;
  logic [COORD_W-1:0] box_x_q, box_x_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic               req_valid_c;
  logic [COORD_W-1:0] x_c, y_c;
  logic [WIDE_W-1:0]  x_w_c, y_w_c, box_w_c, top_w_c, box_end_c;
  logic               in_x_c, in_y_c;
  logic [6:0]         col_c;
  logic [4:0]         row_c;
  font_addr_t         font_addr_c;
  logic [PIX_W-1:0]   glyph_row_c;
  logic               glyph_bit_c;
  logic               eof_c;
  logic               step_due_c;
  logic               wrap_c;
  logic               visible_c;

  // Request decode: 1-based request coordinates to 0-based pixel position.
  assign req_valid_c = (pixel_xpos != '0);
  assign x_c         = pixel_xpos - 11'd1;
  assign y_c         = pixel_ypos - 11'd1;

  // Box hit test in 12 bits so box_x+BOX_W and TEXT_Y+CHAR_H cannot wrap.
  assign x_w_c   = {1'b0, x_c};
  assign y_w_c   = {1'b0, y_c};
  assign box_w_c = {1'b0, box_x_q};
  assign top_w_c = {1'b0, TEXT_Y};
  assign in_x_c  = (x_w_c >= box_w_c) && (x_w_c < box_w_c + WIDE_W'(BOX_W));
  assign in_y_c  = (y_w_c >= top_w_c) && (y_w_c < top_w_c + WIDE_W'(CHAR_H));

  // Only the low bits matter once the hit test has passed.
  assign col_c = 7'(x_c - box_x_q);
  assign row_c = 5'(y_c - TEXT_Y);

  assign font_addr_c = '{chr: col_c[6:4], row: row_c};

  lcd_font_rom u_font_rom (
    .addr_i    (font_addr_c),
    .glyph_c_o (glyph_row_c)
  );

  // Column 0 within a character maps to glyph bit 15.
  assign glyph_bit_c = glyph_row_c[~col_c[3:0]];

  // End of frame is the request for the last active pixel.
  assign eof_c      = (pixel_xpos == h_disp) && (pixel_ypos == v_disp);
  assign step_due_c = (div_q == SCROLL_DIV - 8'd1);
  assign box_end_c  = box_w_c + WIDE_W'(BOX_W) + {1'b0, X_STEP};
  assign wrap_c     = (box_end_c > {1'b0, h_disp});

`ifdef LCD_CHAR_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               hidden_q, hidden_d;

  // Visibility flips on the frame that wraps the 5-bit frame counter.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    hidden_d    = hidden_q;
    if (eof_c) begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      if (blink_cnt_q == '1) hidden_d = ~hidden_q;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
    end
  end

  assign visible_c = ~hidden_q;
`else
  assign visible_c = 1'b1;
`endif

  // Scroll position and frame divider; box_x only moves at end of frame.
  always_comb begin
    box_x_d = box_x_q;
    div_d   = div_q;
    if (eof_c) begin
      if (step_due_c) begin
        div_d   = '0;
        box_x_d = wrap_c ? '0 : box_x_q + X_STEP;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  // Pixel colour and frame pulse for the next cycle.
  always_comb begin
    pixel_d      = RGB_BLACK;
    frame_done_d = eof_c;
    if (req_valid_c) begin
      pixel_d = BG_COLOR;
      if (in_x_c && in_y_c && visible_c && glyph_bit_c) pixel_d = FG_COLOR;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      pixel_q      <= RGB_BLACK;
      frame_done_q <= 1'b0;
      box_x_q      <= '0;
      div_q        <= '0;
    end else begin
      pixel_q      <= pixel_d;
      frame_done_q <= frame_done_d;
      box_x_q      <= box_x_d;
      div_q        <= div_d;
    end
  end

  assign pixel_data = pixel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_disp.sv
// Scoreboard bench for lcd_char_disp: the driver queues the expected
// pixel/frame_done for every request, the monitor compares one cycle later.
module tb_lcd_char_disp;

  localparam logic [15:0] FG = 16'hF800;
  localparam logic [15:0] BG = 16'hFFFF;
  localparam logic [10:0] TY = 11'd120;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic [15:0] pixel_data;
  logic        frame_done;

  always #5 clk = ~clk;

  lcd_char_disp #(
    .TEXT_Y     (TY),
    .SCROLL_DIV (8'd2),
    .X_STEP     (11'd1),
    .FG_COLOR   (FG),
    .BG_COLOR   (BG)
  ) dut (
    .lcd_pclk   (clk),
    .rst        (rst),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .pixel_data (pixel_data),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [15:0] pix;
    logic        fd;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference scroll/blink state, advanced per end-of-frame request.
  int   exp_box, exp_div, exp_fc;
  bit   exp_vis;

  task automatic model_reset();
    exp_box = 0; exp_div = 0; exp_fc = 0; exp_vis = 1'b1;
  endtask

  task automatic drive(input logic r, input logic [10:0] xp, input logic [10:0] yp,
                       input logic [15:0] ep, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; pixel_xpos = xp; pixel_ypos = yp;
    e.pix  = r ? 16'h0000 : ep;
    e.fd   = !r && (xp == h_disp) && (yp == v_disp);
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic set_res(input logic [10:0] h, input logic [10:0] v);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; pixel_xpos = '0; pixel_ypos = '0; h_disp = h; v_disp = v;
    e.pix = 16'h0000; e.fd = 1'b0; e.name = "res_change";
    q.push_back(e);
  endtask

  // Last-pixel request of a frame (always outside the box), then advance the model.
  task automatic eof_frame();
    drive(1'b0, h_disp, v_disp, BG, "eof_pixel");
    if (exp_div == 1) begin
      exp_div = 0;
      if (exp_box + 128 + 1 > int'(h_disp)) exp_box = 0;
      else exp_box = exp_box + 1;
    end else begin
      exp_div = exp_div + 1;
    end
`ifdef LCD_CHAR_BLINK_EN
    if (exp_fc == 31) exp_vis = !exp_vis;
    exp_fc = (exp_fc + 1) % 32;
`endif
  endtask

  // Pixel at a box-relative column; fg says whether the glyph bit is set there.
  task automatic probe(input int col, input logic [10:0] yp, input bit fg, input string nm);
    drive(1'b0, 11'(exp_box + col + 1), yp, (fg && exp_vis) ? FG : BG, nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      checks++;
      if (pixel_data !== mon_e.pix) begin
        errors++;
        $display("FAIL %s pixel_data got %h want %h", mon_e.name, pixel_data, mon_e.pix);
      end
      checks++;
      if (frame_done !== mon_e.fd) begin
        errors++;
        $display("FAIL %s frame_done got %b want %b", mon_e.name, frame_done, mon_e.fd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pixel_xpos = '0; pixel_ypos = '0;
    h_disp = 11'd480; v_disp = 11'd272;
    model_reset();

    repeat (3) drive(1'b1, 11'd5, 11'd5, 16'h0000, "reset_hold");

    // Static glyph samples with box_x = 0 ("HELLO !!", 2x-scaled 8x16 font).
    drive(1'b0, 11'd1,   TY + 11'd1, BG, "char0_row0_bit15");
    drive(1'b0, 11'd3,   11'd129,    FG, "H_col2");
    drive(1'b0, 11'd2,   11'd129,    BG, "H_col1");
    drive(1'b0, 11'd11,  11'd129,    FG, "H_col10");
    drive(1'b0, 11'd9,   11'd129,    BG, "H_col8");
    drive(1'b0, 11'd19,  11'd127,    FG, "E_top_bar");
    drive(1'b0, 11'd17,  11'd127,    BG, "E_col0");
    drive(1'b0, 11'd45,  11'd145,    FG, "L_base");
    drive(1'b0, 11'd45,  11'd137,    BG, "L_stem_gap");
    drive(1'b0, 11'd35,  11'd137,    FG, "L_stem");
    drive(1'b0, 11'd85,  11'd137,    BG, "space");
    drive(1'b0, 11'd103, 11'd129,    FG, "bang6");
    drive(1'b0, 11'd107, 11'd129,    BG, "bang6_gap");
    drive(1'b0, 11'd120, 11'd129,    FG, "bang7");
    drive(1'b0, 11'd129, 11'd129,    BG, "right_of_box");
    drive(1'b0, 11'd3,   11'd120,    BG, "above_box");
    drive(1'b0, 11'd200, 11'd10,     BG, "outside");
    drive(1'b0, 11'd0,   11'd10,     16'h0000, "no_request");
    drive(1'b0, 11'd0,   11'd0,      16'h0000, "idle");

    // Two frames with SCROLL_DIV=2: box moves 0 -> 1 only after the second.
    eof_frame();
    drive(1'b0, 11'd3, 11'd129, FG, "f1_fg");
    drive(1'b0, 11'd2, 11'd129, BG, "f1_bg");
    eof_frame();
    drive(1'b0, 11'd4, 11'd129, FG, "f2_shift_fg");
    drive(1'b0, 11'd3, 11'd129, BG, "f2_shift_bg");

    // Scroll up to box_x = 352, then wrap (352+128+1 > 480).
    repeat (702) eof_frame();
    drive(1'b0, 11'd355, 11'd129, FG, "box352_fg");
    drive(1'b0, 11'd354, 11'd129, BG, "box352_bg");
    eof_frame();
    drive(1'b0, 11'd355, 11'd129, FG, "box352_hold");
    eof_frame();
    drive(1'b0, 11'd3,   11'd129, FG, "wrap_fg");
    drive(1'b0, 11'd355, 11'd129, BG, "wrap_old_pos");

    // Narrow display: box stays at 0.
    set_res(11'd100, 11'd50);
    eof_frame();
    eof_frame();
    drive(1'b0, 11'd3, 11'd129, FG, "narrow_box0");
    set_res(11'd480, 11'd272);

    // Mid-run reset clears box and divider.
    eof_frame();
    eof_frame();
    eof_frame();
    probe(2, 11'd129, 1'b1, "pre_reset_box1");
    drive(1'b1, 11'd3, 11'd129, 16'h0000, "mid_reset");
    model_reset();
    drive(1'b0, 11'd3, 11'd129, FG, "after_reset");
    eof_frame();
    drive(1'b0, 11'd3, 11'd129, FG, "div_cleared");
    eof_frame();
    drive(1'b0, 11'd4, 11'd129, FG, "post_reset_scroll");

    // Blink window: hidden for frames 32..63 when enabled, else always visible.
    repeat (29) eof_frame();
    probe(2, 11'd129, 1'b1, "blink_f31");
    eof_frame();
    probe(2, 11'd129, 1'b1, "blink_f32");
    probe(1, 11'd129, 1'b0, "blink_f32_bg");
    drive(1'b0, 11'd200, 11'd10, BG, "blink_outside");
    repeat (32) eof_frame();
    probe(2, 11'd129, 1'b1, "blink_f64");

    drive(1'b0, 11'd0, 11'd0, 16'h0000, "drain");
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
